// File: rtl/fpu_mem_arbiter_pkg.sv
// Shared types for the FPU memory arbiter: FSM state, request record, default widths
// and the round-robin wrap helper.
package fpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  r_en;
    logic                  w_en;
    logic [DEF_ADDR_W-1:0] ptr;
    logic [DEF_DATA_W-1:0] data_store;
  } mem_req_t;

  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fpu_mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after i_ptr, modulo N.
module rr_picker
  import fpu_mem_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // scan from farthest to nearest so the nearest requester wins
  always_comb begin
    o_valid = 1'b0;
    o_idx   = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_valid = 1'b1;
        o_idx   = IW'((int'(i_ptr) + k) % N);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/fpu_mem_arbiter.sv
// Round-robin sharing of one memory port among NUM_CLIENTS FPU op engines.
// Optional GRANT watchdog enabled by defining FPU_MEM_ARB_TIMEOUT_EN.
module fpu_mem_arbiter
  import fpu_mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
`ifdef FPU_MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT   = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cli_avail,
  input  logic [NUM_CLIENTS-1:0]        cli_r_en,
  input  logic [NUM_CLIENTS-1:0]        cli_w_en,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_ptr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_data_store,
  output logic [NUM_CLIENTS-1:0]        cli_done,
  output logic [DATA_W-1:0]             cli_data_load,
  output logic                          mem_avail,
  output logic                          mem_r_en,
  output logic                          mem_w_en,
  output logic [ADDR_W-1:0]             mem_ptr,
  output logic [DATA_W-1:0]             mem_data_store,
  input  logic                          mem_done,
  input  logic [DATA_W-1:0]             mem_data_load,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int IW = $clog2(NUM_CLIENTS);

  arb_state_t         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant_id;
  logic               r_mem_avail;
  logic               r_mem_r_en;
  logic               r_mem_w_en;
  logic [ADDR_W-1:0]  r_mem_ptr;
  logic [DATA_W-1:0]  r_mem_data_store;
  logic               r_busy;

  logic [NUM_CLIENTS-1:0] w_req;
  logic                   w_pick_valid;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_timeout;
  logic                   w_finish;

  assign w_req    = cli_avail & (cli_r_en | cli_w_en);
  assign w_finish = (r_state == GRANT) && (mem_done || w_timeout);

  rr_picker #(.N(NUM_CLIENTS), .IW(IW)) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

`ifdef FPU_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout   = (r_state == GRANT) && !mem_done && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign err_timeout = r_err;

  // GRANT cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_err <= 1'b0;
    end else if (r_state == GRANT) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end else begin
      r_cnt <= {CNT_W{1'b0}};
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // done goes straight to the granted client; suppressed while reset abandons the grant
  always_comb begin
    cli_done = {NUM_CLIENTS{1'b0}};
    if (!rst && w_finish) begin
      cli_done[r_grant_id] = 1'b1;
    end else begin
      cli_done = {NUM_CLIENTS{1'b0}};
    end
  end

  assign cli_data_load = w_timeout ? {DATA_W{1'b0}} : mem_data_load;

  // arbitration FSM with registered memory-side request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_rr_ptr         <= {IW{1'b0}};
      r_grant_id       <= {IW{1'b0}};
      r_mem_avail      <= 1'b0;
      r_mem_r_en       <= 1'b0;
      r_mem_w_en       <= 1'b0;
      r_mem_ptr        <= {ADDR_W{1'b0}};
      r_mem_data_store <= {DATA_W{1'b0}};
      r_busy           <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant_id       <= w_pick_idx;
            r_mem_ptr        <= cli_ptr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_mem_data_store <= cli_data_store[int'(w_pick_idx)*DATA_W +: DATA_W];
            r_mem_w_en       <= cli_w_en[w_pick_idx];
            r_mem_r_en       <= cli_r_en[w_pick_idx] & ~cli_w_en[w_pick_idx];
            r_mem_avail      <= 1'b1;
            r_busy           <= 1'b1;
            r_state          <= GRANT;
          end
        end
        GRANT: begin
          if (w_finish) begin
            r_mem_avail <= 1'b0;
            r_mem_r_en  <= 1'b0;
            r_mem_w_en  <= 1'b0;
            r_rr_ptr    <= IW'(rr_wrap(32'(r_grant_id), 32'(NUM_CLIENTS)));
            r_state     <= RELEASE;
          end
        end
        RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_avail      = r_mem_avail;
  assign mem_r_en       = r_mem_r_en;
  assign mem_w_en       = r_mem_w_en;
  assign mem_ptr        = r_mem_ptr;
  assign mem_data_store = r_mem_data_store;
  assign grant_id       = r_grant_id;
  assign busy           = r_busy;

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Scoreboard bench for fpu_mem_arbiter; the watchdog scenario runs when FPU_MEM_ARB_TIMEOUT_EN is defined.
module tb_fpu_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef FPU_MEM_ARB_TIMEOUT_EN
  localparam int EXP_DONES = 13;
`else
  localparam int EXP_DONES = 11;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cli_avail, cli_r_en, cli_w_en;
  logic [N*AW-1:0] cli_ptr;
  logic [N*DW-1:0] cli_data_store;
  logic [N-1:0]    cli_done;
  logic [DW-1:0]   cli_data_load;
  logic            mem_avail, mem_r_en, mem_w_en;
  logic [AW-1:0]   mem_ptr;
  logic [DW-1:0]   mem_data_store;
  logic            mem_done;
  logic [DW-1:0]   mem_data_load;
  logic [1:0]      grant_id;
  logic            busy, err_timeout;

  always #5 clk = ~clk;

  fpu_mem_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef FPU_MEM_ARB_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) u_dut (
    .clk(clk), .rst(rst),
    .cli_avail(cli_avail), .cli_r_en(cli_r_en), .cli_w_en(cli_w_en),
    .cli_ptr(cli_ptr), .cli_data_store(cli_data_store),
    .cli_done(cli_done), .cli_data_load(cli_data_load),
    .mem_avail(mem_avail), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_ptr(mem_ptr), .mem_data_store(mem_data_store),
    .mem_done(mem_done), .mem_data_load(mem_data_load),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    int          client;
    logic        w;
    logic        r;
    logic [31:0] ptr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   mem_lat = 3;
  bit   mem_en = 1'b1;
  int   stray_req = 0;
  int   stray_ack = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic w, input logic r,
                          input logic [31:0] p, input logic [31:0] d, input logic [31:0] rd);
    exp_t e;
    e.client = c; e.w = w; e.r = r; e.ptr = p; e.wdata = d; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic set_client(input int i, input logic av, input logic r, input logic w,
                            input logic [31:0] p, input logic [31:0] d);
    cli_avail[i] = av;
    cli_r_en[i]  = r;
    cli_w_en[i]  = w;
    cli_ptr[i*AW +: AW]        = p;
    cli_data_store[i*DW +: DW] = d;
  endtask

  task automatic wait_done(input int c, input int bound, output int cyc);
    cyc = 0;
    checks++;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cli_done[c] && cyc < bound);
    if (!cli_done[c]) begin
      errors++;
      $display("FAIL done_wait client=%0d actual=none required=pulse", c);
    end
  endtask

  // memory: 0x40 holds -1.0f, everything else reads ptr ^ 0xFFFF0000
  function automatic logic [31:0] mem_fn(input logic [31:0] p);
    if (p == 32'h0000_0040) return 32'hBF80_0000;
    else return p ^ 32'hFFFF_0000;
  endfunction

  initial begin : memory_model
    int mcnt;
    mcnt = 0;
    mem_done = 1'b0;
    mem_data_load = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        mem_done = 1'b1;
        mem_data_load = 32'h1111_2222;
      end else if (mem_avail && mem_en) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          mem_done = 1'b1;
          mem_data_load = mem_fn(mem_ptr);
          mcnt = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t cur;
    bit   cur_v;
    bit   prev_avail;
    cur_v = 1'b0;
    prev_avail = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_v = 1'b0;
        prev_avail = 1'b0;
      end else begin
        if (mem_avail && !prev_avail) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected actual=client%0d required=none", grant_id);
          end else begin
            cur = exp_q.pop_front();
            cur_v = 1'b1;
            chk("grant_id", 32'(grant_id), 32'(cur.client));
            chk("mem_w_en", 32'(mem_w_en), 32'(cur.w));
            chk("mem_r_en", 32'(mem_r_en), 32'(cur.r));
            chk("mem_ptr", mem_ptr, cur.ptr);
            chk("mem_data_store", mem_data_store, cur.wdata);
            chk("busy_grant", 32'(busy), 32'd1);
          end
        end
        if (cli_done != '0) begin
          n_done++;
          if (!cur_v) begin
            checks++; errors++;
            $display("FAIL done_unexpected actual=%b required=0000", cli_done);
          end else begin
            chk("cli_done", 32'(cli_done), 32'd1 << cur.client);
            chk("cli_data_load", cli_data_load, cur.rdata);
            chk("ptr_frozen", mem_ptr, cur.ptr);
            cur_v = 1'b0;
          end
        end
        prev_avail = mem_avail;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_avail"}, 32'(mem_avail), 32'd0);
    chk({tag, "_r_en"}, 32'(mem_r_en), 32'd0);
    chk({tag, "_w_en"}, 32'(mem_w_en), 32'd0);
    chk({tag, "_ptr"}, mem_ptr, 32'd0);
    chk({tag, "_wdata"}, mem_data_store, 32'd0);
    chk({tag, "_done"}, 32'(cli_done), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin : stimulus
    int cyc;
    int order [6] = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    cli_avail = '0; cli_r_en = '0; cli_w_en = '0; cli_ptr = '0; cli_data_store = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // single read, client 2, latency 3
    repeat (2) @(posedge clk); #1;
    mem_lat = 3;
    push_exp(2, 1'b0, 1'b1, 32'h40, 32'h0, 32'hBF80_0000);
    set_client(2, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk); chk("avail_before_edge", 32'(mem_avail), 32'd0);
    @(negedge clk); chk("avail_one_cycle", 32'(mem_avail), 32'd1);
    wait_done(2, 20, cyc);
    chk("busy_at_done", 32'(busy), 32'd1);
    @(posedge clk); #1 set_client(2, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    chk("busy_release", 32'(busy), 32'd1);
    chk("done_one_cycle", 32'(cli_done), 32'd0);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("no_regrant", 32'(mem_avail), 32'd0);

    // stray mem_done in IDLE
    stray_req++;
    @(posedge clk); @(negedge clk);
    chk("stray_done", 32'(cli_done), 32'd0);
    chk("stray_avail", 32'(mem_avail), 32'd0);

    // reset the rr pointer, then three writers contend
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mem_lat = 1;
    for (int k = 0; k < 6; k++) begin
      push_exp(order[k], 1'b1, 1'b0, 32'h100 + 32'(order[k]) * 32'd4,
               32'hA000_0000 + 32'(order[k]) * 32'h0111_1111,
               (32'h100 + 32'(order[k]) * 32'd4) ^ 32'hFFFF_0000);
    end
    for (int i = 0; i < N; i++) begin
      if (i != 2) set_client(i, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i) * 32'd4,
                             32'hA000_0000 + 32'(i) * 32'h0111_1111);
    end
    for (int k = 0; k < 6; k++) wait_done(order[k], 20, cyc);
    @(posedge clk); #1 cli_avail = '0; cli_w_en = '0;

    // client 1 with both r_en and w_en: write wins
    repeat (2) @(posedge clk); #1;
    mem_lat = 2;
    push_exp(1, 1'b1, 1'b0, 32'h180, 32'h1234_5678, 32'hFFFF_0180);
    set_client(1, 1'b1, 1'b1, 1'b1, 32'h180, 32'h1234_5678);
    wait_done(1, 20, cyc);
    @(posedge clk); #1 set_client(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // client 0 drops avail and changes ptr mid-GRANT
    repeat (2) @(posedge clk); #1;
    mem_lat = 4;
    push_exp(0, 1'b0, 1'b1, 32'h200, 32'h0, 32'hFFFF_0200);
    set_client(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 set_client(0, 1'b0, 1'b0, 1'b0, 32'h300, 32'hFFFF_FFFF);
    @(negedge clk); chk("mid_grant_ptr", mem_ptr, 32'h200);
    wait_done(0, 20, cyc);

`ifdef FPU_MEM_ARB_TIMEOUT_EN
    // memory never answers client 1; then client 2 is served normally
    repeat (2) @(posedge clk); #1;
    mem_en = 1'b0;
    push_exp(1, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0);
    set_client(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    wait_done(1, 40, cyc);
    chk("timeout_cycles", 32'(cyc), 32'd17);
    chk("err_before_edge", 32'(err_timeout), 32'd0);
    @(posedge clk); #1 set_client(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_en = 1'b1;
    @(negedge clk); chk("err_set", 32'(err_timeout), 32'd1);
    mem_lat = 2;
    push_exp(2, 1'b0, 1'b1, 32'h84, 32'h0, 32'hFFFF_0084);
    set_client(2, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0);
    wait_done(2, 20, cyc);
    @(posedge clk); #1 set_client(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk("err_sticky", 32'(err_timeout), 32'd1);
`endif

    // reset lands in GRANT together with mem_done
    repeat (2) @(posedge clk); #1;
    mem_lat = 3;
    push_exp(2, 1'b0, 1'b1, 32'h88, 32'h0, 32'hFFFF_0088);
    set_client(2, 1'b1, 1'b1, 1'b0, 32'h88, 32'h0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    set_client(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_client(0, 1'b1, 1'b1, 1'b0, 32'h8C, 32'h0);
    set_client(3, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0);
    push_exp(0, 1'b0, 1'b1, 32'h8C, 32'h0, 32'hFFFF_008C);
    push_exp(3, 1'b0, 1'b1, 32'h90, 32'h0, 32'hFFFF_0090);
    @(negedge clk);
    chk("rst_done_pending", 32'(mem_done), 32'd1);
    chk("rst_done_masked", 32'(cli_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_rst");
    wait_done(0, 20, cyc);
    @(posedge clk); #1 set_client(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done(3, 20, cyc);
    @(posedge clk); #1 set_client(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(EXP_DONES));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
